// File: rtl/hazard_ctrl.sv
// Hazard/sequencing controller for the F/D/E/M/W pipe: stalls, flushes,
// E-stage forwarding selects, per-stage valid bits and a data-memory wait FSM.
// Ports: clk, reset (sync, active-low); RA*/WA* register addresses;
//   RegWrite*/MemtoRegE/MemAccessM/MemReadyM/PCSrc*/BranchTakenE status in;
//   ForwardAE/BE, StallF/D/E/M, FlushD/E, MemErr control out.
// Optional: define HAZARD_PERF_EN to add saturating StallCnt/FlushCnt outputs.
module hazard_ctrl #(
    parameter int TIMEOUT = 16,
    parameter int CW      = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [3:0]    RA1D,
    input  logic [3:0]    RA2D,
    input  logic [3:0]    RA1E,
    input  logic [3:0]    RA2E,
    input  logic [3:0]    WA3E,
    input  logic [3:0]    WA3M,
    input  logic [3:0]    WA3W,
    input  logic          RegWriteE,
    input  logic          RegWriteM,
    input  logic          RegWriteW,
    input  logic          MemtoRegE,
    input  logic          MemAccessM,
    input  logic          MemReadyM,
    input  logic          PCSrcD,
    input  logic          PCSrcE,
    input  logic          PCSrcM,
    input  logic          PCSrcW,
    input  logic          BranchTakenE,
    output logic [1:0]    ForwardAE,
    output logic [1:0]    ForwardBE,
    output logic          StallF,
    output logic          StallD,
    output logic          StallE,
    output logic          StallM,
    output logic          FlushD,
    output logic          FlushE,
`ifdef HAZARD_PERF_EN
    output logic [CW-1:0] StallCnt,
    output logic [CW-1:0] FlushCnt,
`endif
    output logic          MemErr
);

    localparam logic [1:0] S_RUN   = 2'd0;
    localparam logic [1:0] S_MWAIT = 2'd1;
    localparam logic [1:0] S_ERR   = 2'd2;

    localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          vd_q, vd_d, ve_q, ve_d, vm_q, vm_d, vw_q, vw_d;

    logic ldr, pcp, bt, mem_req, ms;
    logic hit_am, hit_aw, hit_bm, hit_bw;
    logic stall_fi, stall_di, flush_di, flush_ei;

    // Load-use detection keys on MemtoRegE alone; RegWriteE is
    // accepted for interface completeness only.
    logic unused_regwrite_e;
    assign unused_regwrite_e = RegWriteE;

    assign ldr = vd_q & ve_q & MemtoRegE
               & ((WA3E == RA1D) | (WA3E == RA2D));
    assign pcp = (vd_q & PCSrcD) | (ve_q & PCSrcE) | (vm_q & PCSrcM);
    assign bt  = ve_q & BranchTakenE;

    assign mem_req = vm_q & MemAccessM & ~MemReadyM;
    assign ms = ((state_q == S_RUN) & mem_req)
              | ((state_q == S_MWAIT) & ~MemReadyM)
              | (state_q == S_ERR);

    // R15 is the PC, never a forwardable result.
    assign hit_am = vm_q & RegWriteM & (WA3M == RA1E) & (WA3M != 4'hF);
    assign hit_aw = vw_q & RegWriteW & (WA3W == RA1E) & (WA3W != 4'hF);
    assign hit_bm = vm_q & RegWriteM & (WA3M == RA2E) & (WA3M != 4'hF);
    assign hit_bw = vw_q & RegWriteW & (WA3W == RA2E) & (WA3W != 4'hF);

    // Internal (unforced) controls; a memory stall masks every flush.
    assign stall_fi = ms | ldr | pcp;
    assign stall_di = ms | ldr;
    assign flush_ei = ~ms & (ldr | bt);
    assign flush_di = ~ms & (pcp | (vw_q & PCSrcW) | bt);

    always_comb begin
        StallF    = stall_fi;
        StallD    = stall_di;
        StallE    = ms;
        StallM    = ms;
        FlushD    = flush_di;
        FlushE    = flush_ei;
        MemErr    = (state_q == S_ERR);
        ForwardAE = hit_am ? 2'b10 : (hit_aw ? 2'b01 : 2'b00);
        ForwardBE = hit_bm ? 2'b10 : (hit_bw ? 2'b01 : 2'b00);
        if (!reset) begin
            StallF    = 1'b0;
            StallD    = 1'b0;
            StallE    = 1'b0;
            StallM    = 1'b0;
            FlushD    = 1'b1;
            FlushE    = 1'b1;
            MemErr    = 1'b0;
            ForwardAE = 2'b00;
            ForwardBE = 2'b00;
        end
    end

    always_comb begin
        vd_d = stall_di ? 1'b1 : ~flush_di;
        ve_d = ms ? ve_q : (vd_q & ~flush_ei);
        vm_d = ms ? vm_q : ve_q;
        // M waiting sends a bubble into W.
        vw_d = vm_q & ~ms;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_RUN: begin
                if (mem_req) begin
                    state_d = S_MWAIT;
                    cnt_d   = CNT_ONE;
                end
            end
            S_MWAIT: begin
                if (MemReadyM) begin
                    state_d = S_RUN;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_ERR;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_ERR: begin
                state_d = S_ERR;
            end
            default: begin
                state_d = S_RUN;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_RUN;
            cnt_q   <= '0;
            vd_q    <= 1'b0;
            ve_q    <= 1'b0;
            vm_q    <= 1'b0;
            vw_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            vd_q    <= vd_d;
            ve_q    <= ve_d;
            vm_q    <= vm_d;
            vw_q    <= vw_d;
        end
    end

`ifdef HAZARD_PERF_EN
    logic [CW-1:0] stall_cnt_q, stall_cnt_d;
    logic [CW-1:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (StallD && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_ONE;
        end
        if (FlushE && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign StallCnt = stall_cnt_q;
    assign FlushCnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus a randomized
// run against a behavioural model of the pipeline rules.
module tb_hazard_ctrl;

    localparam int TO = 4;
    localparam int CW = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic [3:0] RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W;
    logic       RegWriteE, RegWriteM, RegWriteW, MemtoRegE;
    logic       MemAccessM, MemReadyM;
    logic       PCSrcD, PCSrcE, PCSrcM, PCSrcW, BranchTakenE;
    logic [1:0] ForwardAE, ForwardBE;
    logic       StallF, StallD, StallE, StallM, FlushD, FlushE, MemErr;
`ifdef HAZARD_PERF_EN
    logic [CW-1:0] StallCnt, FlushCnt;
`endif

    hazard_ctrl #(.TIMEOUT(TO), .CW(CW)) dut (
        .clk(clk), .reset(reset),
        .RA1D(RA1D), .RA2D(RA2D), .RA1E(RA1E), .RA2E(RA2E),
        .WA3E(WA3E), .WA3M(WA3M), .WA3W(WA3W),
        .RegWriteE(RegWriteE), .RegWriteM(RegWriteM),
        .RegWriteW(RegWriteW), .MemtoRegE(MemtoRegE),
        .MemAccessM(MemAccessM), .MemReadyM(MemReadyM),
        .PCSrcD(PCSrcD), .PCSrcE(PCSrcE), .PCSrcM(PCSrcM),
        .PCSrcW(PCSrcW), .BranchTakenE(BranchTakenE),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .StallF(StallF), .StallD(StallD), .StallE(StallE),
        .StallM(StallM), .FlushD(FlushD), .FlushE(FlushE),
`ifdef HAZARD_PERF_EN
        .StallCnt(StallCnt), .FlushCnt(FlushCnt),
`endif
        .MemErr(MemErr)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Behavioural model: which stages hold real instructions, how many
    // consecutive cycles the current memory access has stalled, error flag.
    bit mvD, mvE, mvM, mvW, merr;
    int mwait;
    int mscnt, mfcnt;

    logic e_ms, e_sF, e_sD, e_sE, e_sM, e_fD, e_fE, e_err;
    logic [1:0] e_fa, e_fb;
    logic [10:0] exp_out, dut_out;

    function automatic logic [1:0] src_for(
        input logic [3:0] ra, input bit vm, input bit vw,
        input logic rwm, input logic [3:0] wm,
        input logic rww, input logic [3:0] ww);
        if (ra == 4'd15) return 2'b00;
        if (vm && rwm && wm == ra) return 2'b10;
        if (vw && rww && ww == ra) return 2'b01;
        return 2'b00;
    endfunction

    always_comb begin
        logic ldu, pend, bt;
        e_ms = 0; e_sF = 0; e_sD = 0; e_sE = 0; e_sM = 0;
        e_fD = 1; e_fE = 1; e_err = 0; e_fa = 0; e_fb = 0;
        ldu = 0; pend = 0; bt = 0;
        if (reset) begin
            e_ms = merr || (!MemReadyM
                 && (mwait > 0 || (mvM && MemAccessM)));
            ldu = mvD && mvE && MemtoRegE
                && (WA3E == RA1D || WA3E == RA2D);
            pend = (mvD && PCSrcD) || (mvE && PCSrcE)
                 || (mvM && PCSrcM);
            bt = mvE && BranchTakenE;
            if (e_ms) begin
                {e_sF, e_sD, e_sE, e_sM} = 4'b1111;
                e_fD = 0; e_fE = 0;
            end else begin
                e_sF = ldu || pend;
                e_sD = ldu;
                e_fE = ldu || bt;
                e_fD = pend || (mvW && PCSrcW) || bt;
            end
            e_fa = src_for(RA1E, mvM, mvW, RegWriteM, WA3M,
                           RegWriteW, WA3W);
            e_fb = src_for(RA2E, mvM, mvW, RegWriteM, WA3M,
                           RegWriteW, WA3W);
            e_err = merr;
        end
    end

    assign exp_out = {e_sF, e_sD, e_sE, e_sM, e_fD, e_fE,
                      e_fa, e_fb, e_err};
    assign dut_out = {StallF, StallD, StallE, StallM, FlushD, FlushE,
                      ForwardAE, ForwardBE, MemErr};

    task automatic tick();
        bit nD, nE, nM, nW;
        @(posedge clk);
        if (!reset) begin
            {mvD, mvE, mvM, mvW, merr} = '0;
            mwait = 0; mscnt = 0; mfcnt = 0;
        end else begin
            nD = e_sD ? 1'b1 : !e_fD;
            nE = e_sE ? mvE : (mvD && !e_fE);
            nM = e_sM ? mvM : mvE;
            nW = mvM && !e_sM;
            {mvD, mvE, mvM, mvW} = {nD, nE, nM, nW};
            if (!merr) begin
                if (e_ms) begin
                    mwait++;
                    if (mwait >= TO) merr = 1;
                end else begin
                    mwait = 0;
                end
            end
            if (e_sD && mscnt < 255) mscnt++;
            if (e_fE && mfcnt < 255) mfcnt++;
        end
        #1;
    endtask

    task automatic quiet();
        reset = 1;
        {RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W} = '0;
        {RegWriteE, RegWriteM, RegWriteW, MemtoRegE} = '0;
        {MemAccessM, PCSrcD, PCSrcE, PCSrcM, PCSrcW} = '0;
        BranchTakenE = 0;
        MemReadyM = 1;
    endtask

    task automatic test_reset();
        quiet();
        reset = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_cmp++;
            if (dut_out !== 11'b0000_11_00_00_0) begin
                n_bad++;
                $display("FAIL reset_hold[%0d]: got %b want %b",
                         i, dut_out, 11'b0000_11_00_00_0);
            end
            tick();
        end
        reset = 1;
        #1;
        n_cmp++;
        if (dut_out !== 11'b0) begin
            n_bad++;
            $display("FAIL reset_release: got %b want %b",
                     dut_out, 11'b0);
        end
        tick();
    endtask

    task automatic test_forward();
        quiet();
        repeat (4) tick();
        RegWriteM = 1; WA3M = 1; RegWriteW = 1; WA3W = 1;
        RA1E = 1; RA2E = 1;
        #1;
        n_cmp++;
        if ({ForwardAE, ForwardBE} !== 4'b1010) begin
            n_bad++;
            $display("FAIL fwd_m_prio: got %b want %b",
                     {ForwardAE, ForwardBE}, 4'b1010);
        end
        RegWriteM = 0;
        #1;
        n_cmp++;
        if (ForwardAE !== 2'b01) begin
            n_bad++;
            $display("FAIL fwd_w_only: got %b want 01", ForwardAE);
        end
        RegWriteM = 1; WA3M = 15; WA3W = 15; RA1E = 15; RA2E = 15;
        #1;
        n_cmp++;
        if ({ForwardAE, ForwardBE} !== 4'b0000) begin
            n_bad++;
            $display("FAIL fwd_r15: got %b want 0000",
                     {ForwardAE, ForwardBE});
        end
        quiet();
        tick();
    endtask

    task automatic test_load_use();
        quiet();
        tick();
        MemtoRegE = 1; RegWriteE = 1; WA3E = 2; RA2D = 2; RA1D = 7;
        #1;
        n_cmp++;
        if ({StallF, StallD, StallE, FlushE} !== 4'b1101) begin
            n_bad++;
            $display("FAIL ldr_first: got %b want 1101",
                     {StallF, StallD, StallE, FlushE});
        end
        tick();
        #1;
        n_cmp++;
        if ({StallF, StallD, FlushE} !== 3'b000) begin
            n_bad++;
            $display("FAIL ldr_once: got %b want 000",
                     {StallF, StallD, FlushE});
        end
        quiet();
        tick();
        RegWriteW = 1; WA3W = 2; RA2E = 2;
        #1;
        n_cmp++;
        if (ForwardBE !== 2'b01) begin
            n_bad++;
            $display("FAIL ldr_fwd_w: got %b want 01", ForwardBE);
        end
        quiet();
        tick();
    endtask

    task automatic test_branch();
        bit exp_sf[5] = '{1, 1, 1, 0, 0};
        bit exp_fd[5] = '{1, 1, 1, 1, 0};
        quiet();
        repeat (3) tick();
        BranchTakenE = 1;
        #1;
        n_cmp++;
        if ({FlushD, FlushE} !== 2'b11) begin
            n_bad++;
            $display("FAIL br_flush: got %b want 11", {FlushD, FlushE});
        end
        tick();
        #1;
        n_cmp++;
        if ({FlushD, FlushE} !== 2'b00) begin
            n_bad++;
            $display("FAIL br_bubble: got %b want 00", {FlushD, FlushE});
        end
        quiet();
        repeat (2) tick();
        for (int i = 0; i < 5; i++) begin
            PCSrcD = (i == 0); PCSrcE = (i == 1);
            PCSrcM = (i == 2); PCSrcW = (i == 3);
            #1;
            n_cmp++;
            if ({StallF, FlushD} !== {exp_sf[i], exp_fd[i]}) begin
                n_bad++;
                $display("FAIL pc_seq[%0d]: got %b want %b", i,
                         {StallF, FlushD}, {exp_sf[i], exp_fd[i]});
            end
            tick();
        end
        quiet();
        tick();
    endtask

    task automatic test_mem_wait();
        quiet();
        repeat (4) tick();
        for (int i = 0; i < 4; i++) begin
            MemAccessM = 1; MemReadyM = (i == 3);
            RegWriteW = 1; WA3W = 3; RA1E = 3;
            if (i >= 1) begin
                MemtoRegE = 1; WA3E = 5; RA1D = 5;
            end
            #1;
            n_cmp++;
            if (i < 3) begin
                if ({StallF, StallD, StallE, StallM, FlushD, FlushE,
                     ForwardAE} !== {6'b111100,
                     (i == 0) ? 2'b01 : 2'b00}) begin
                    n_bad++;
                    $display("FAIL mwait[%0d]: got %b", i,
                             {StallF, StallD, StallE, StallM,
                              FlushD, FlushE, ForwardAE});
                end
            end else begin
                if ({StallF, StallD, StallE, StallM, FlushE,
                     ForwardAE} !== 7'b1100100) begin
                    n_bad++;
                    $display("FAIL mwait_resume: got %b want 1100100",
                             {StallF, StallD, StallE, StallM,
                              FlushE, ForwardAE});
                end
            end
            tick();
        end
        quiet();
        tick();
    endtask

    task automatic test_timeout();
        quiet();
        reset = 0;
        tick();
        reset = 1;
        repeat (3) tick();
        for (int i = 0; i < 7; i++) begin
            MemAccessM = 1; MemReadyM = (i >= 5); BranchTakenE = 1;
            #1;
            n_cmp++;
            if ({StallF, StallD, StallE, StallM, FlushD, FlushE,
                 MemErr} !== {6'b111100, i >= 4}) begin
                n_bad++;
                $display("FAIL timeout[%0d]: got %b want %b", i,
                         {StallF, StallD, StallE, StallM, FlushD,
                          FlushE, MemErr}, {6'b111100, i >= 4});
            end
`ifdef HAZARD_PERF_EN
            if (i == 4) begin
                n_cmp++;
                if (StallCnt !== 8'd4) begin
                    n_bad++;
                    $display("FAIL stallcnt_err: got %0d want 4",
                             StallCnt);
                end
            end
`endif
            tick();
        end
        reset = 0;
        #1;
        n_cmp++;
        if ({MemErr, StallF, FlushD, FlushE} !== 4'b0011) begin
            n_bad++;
            $display("FAIL err_reset: got %b want 0011",
                     {MemErr, StallF, FlushD, FlushE});
        end
        tick();
        quiet();
        #1;
        n_cmp++;
        if ({MemErr, StallF, StallD, StallE, StallM} !== 5'b0) begin
            n_bad++;
            $display("FAIL err_cleared: got %b want 00000",
                     {MemErr, StallF, StallD, StallE, StallM});
        end
        tick();
    endtask

    function automatic logic [3:0] rreg();
        if ($urandom_range(0, 7) == 0) return 4'd15;
        return 4'($urandom_range(0, 3));
    endfunction

    task automatic test_random();
        for (int n = 0; n < 600; n++) begin
            reset = ($urandom_range(0, 39) == 0
                  || (merr && $urandom_range(0, 3) == 0)) ? 0 : 1;
            RA1D = rreg(); RA2D = rreg(); RA1E = rreg(); RA2E = rreg();
            WA3E = rreg(); WA3M = rreg(); WA3W = rreg();
            RegWriteE = 1'($urandom); RegWriteM = 1'($urandom);
            RegWriteW = 1'($urandom);
            MemtoRegE = ($urandom_range(0, 3) == 0);
            MemAccessM = ($urandom_range(0, 2) == 0);
            MemReadyM = ($urandom_range(0, 3) != 0);
            PCSrcD = ($urandom_range(0, 7) == 0);
            PCSrcE = ($urandom_range(0, 7) == 0);
            PCSrcM = ($urandom_range(0, 7) == 0);
            PCSrcW = ($urandom_range(0, 7) == 0);
            BranchTakenE = ($urandom_range(0, 5) == 0);
            #1;
            n_cmp++;
            if (dut_out !== exp_out) begin
                n_bad++;
                $display("FAIL rand[%0d]: got %b want %b",
                         n, dut_out, exp_out);
            end
`ifdef HAZARD_PERF_EN
            n_cmp++;
            if ({StallCnt, FlushCnt} !== {8'(mscnt), 8'(mfcnt)}) begin
                n_bad++;
                $display("FAIL rand_cnt[%0d]: got %0d/%0d want %0d/%0d",
                         n, StallCnt, FlushCnt, mscnt, mfcnt);
            end
`endif
            tick();
        end
    endtask

    initial begin
        {mvD, mvE, mvM, mvW, merr} = '0;
        mwait = 0; mscnt = 0; mfcnt = 0;
        quiet();
        reset = 0;
        test_reset();
        test_forward();
        test_load_use();
        test_branch();
        test_mem_wait();
        test_timeout();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
